// File: rtl/mem_stage_if.sv
// EXE -> MEM -> WB handshake, data-SRAM response and forwarding bus for mem_stage.
// Optional feature macro: MS_FWD_DATA_EN (widens ms_fwd_blk_bus to carry forward data).
interface mem_stage_if;
  localparam int unsigned ES_TO_MS_BUS_WD = 77;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
`ifdef MS_FWD_DATA_EN
  localparam int unsigned MS_FWD_BLK_BUS_WD = 39;
`else
  localparam int unsigned MS_FWD_BLK_BUS_WD = 6;
`endif

  logic                         ms_allowin;
  logic                         es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
  logic                         ws_allowin;
  logic                         ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
  logic                         data_sram_data_ok;
  logic [31:0]                  data_sram_rdata;
  logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;

  // Stage side
  modport master (
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus,
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata
  );

  // Surrounding pipeline / memory side
  modport slave (
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus,
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches EXE payload, waits for / buffers the
// data-SRAM response, aligns load data and hands the result to WB.
// Optional feature macro: MS_FWD_DATA_EN (forward data + load-block flag to ID).
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.master ms_if
);
  localparam int unsigned ES_TO_MS_BUS_WD = 77;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic                       rdata_ok_r;
  logic [31:0]                rdata_r;

  logic        mem_req;
  logic        is_load;
  logic [2:0]  ld_type;
  logic [1:0]  addr_lo;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic        ms_ready_go;
  logic        ms_leave;
  logic [31:0] mem_rdata;
  logic [7:0]  byte_data;
  logic [15:0] half_data;
  logic [31:0] aligned_data;
  logic [31:0] final_result;
  logic        ms_rf_wen;

  assign mem_req    = es_to_ms_bus_r[76];
  assign is_load    = es_to_ms_bus_r[75];
  assign ld_type    = es_to_ms_bus_r[74:72];
  assign addr_lo    = es_to_ms_bus_r[71:70];
  assign gr_we      = es_to_ms_bus_r[69];
  assign dest       = es_to_ms_bus_r[68:64];
  assign alu_result = es_to_ms_bus_r[63:32];
  assign pc         = es_to_ms_bus_r[31:0];

  assign ms_ready_go          = !mem_req || ms_if.data_sram_data_ok || rdata_ok_r;
  assign ms_if.ms_allowin     = !ms_valid || (ms_ready_go && ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_leave             = ms_if.ms_to_ws_valid && ms_if.ws_allowin;

  // Stage occupancy and payload latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid       <= 1'b0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (ms_if.ms_allowin) begin
        ms_valid <= ms_if.es_to_ms_valid;
      end
      if (ms_if.es_to_ms_valid && ms_if.ms_allowin) begin
        es_to_ms_bus_r <= ms_if.es_to_ms_bus;
      end
    end
  end

  // Hold the data_ok response while WB stalls; cleared when the entry leaves
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_ok_r <= 1'b0;
      rdata_r    <= '0;
    end else if (ms_leave) begin
      rdata_ok_r <= 1'b0;
    end else if (ms_valid && mem_req && !rdata_ok_r && ms_if.data_sram_data_ok) begin
      rdata_ok_r <= 1'b1;
      rdata_r    <= ms_if.data_sram_rdata;
    end
  end

  assign mem_rdata = rdata_ok_r ? rdata_r : ms_if.data_sram_rdata;

  // Byte/halfword lane select and sign/zero extension
  always_comb begin
    byte_data    = mem_rdata[7:0];
    half_data    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    aligned_data = mem_rdata;
    case (addr_lo)
      2'd1:    byte_data = mem_rdata[15:8];
      2'd2:    byte_data = mem_rdata[23:16];
      2'd3:    byte_data = mem_rdata[31:24];
      default: byte_data = mem_rdata[7:0];
    endcase
    case (ld_type)
      3'b001:  aligned_data = {{24{byte_data[7]}}, byte_data};
      3'b010:  aligned_data = {24'h0, byte_data};
      3'b011:  aligned_data = {{16{half_data[15]}}, half_data};
      3'b100:  aligned_data = {16'h0, half_data};
      default: aligned_data = mem_rdata;
    endcase
  end

  assign final_result       = is_load ? aligned_data : alu_result;
  assign ms_if.ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_rf_wen          = ms_valid && gr_we;

`ifdef MS_FWD_DATA_EN
  logic ms_fwd_blk;
  assign ms_fwd_blk           = ms_valid && is_load && !ms_ready_go;
  assign ms_if.ms_fwd_blk_bus = {ms_rf_wen, dest, ms_fwd_blk, final_result};
`else
  assign ms_if.ms_fwd_blk_bus = {ms_rf_wen, dest};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB payloads plus
// per-scenario inline checks. Honours MS_FWD_DATA_EN when defined.
module tb_mem_stage;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [69:0] exp_q[$];

  mem_stage_if ms_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ms_if)
  );

  always #5 clk = ~clk;

  function automatic logic [76:0] mk_es(input logic mr, input logic ld, input logic [2:0] lt,
                                        input logic [1:0] al, input logic we, input logic [4:0] dst,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {mr, ld, lt, al, we, dst, alu, pc};
  endfunction

  function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] dst,
                                        input logic [31:0] res, input logic [31:0] pc);
    return {we, dst, res, pc};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.es_to_ms_bus = '0;
    ms_if.ws_allowin = 1'b1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata = '0;
    #1;
    checks++;
    if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_to_ws_bus !== 70'h0 ||
        ms_if.ms_allowin !== 1'b1 || ms_if.ms_fwd_blk_bus !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b bus=%h allowin=%b fwd=%h, want 0/0/1/0",
               ms_if.ms_to_ws_valid, ms_if.ms_to_ws_bus, ms_if.ms_allowin, ms_if.ms_fwd_blk_bus);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus = mk_es(1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 5'd5, 32'h1234, 32'hBFC00000);
    exp_q.push_back(mk_ws(1'b1, 5'd5, 32'h1234, 32'hBFC00000));
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b0;
    checks++;
    if (ms_if.ms_to_ws_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency: valid=%b want 1", ms_if.ms_to_ws_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ms_if.ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_one_cycle: valid=%b want 0", ms_if.ms_to_ws_valid);
    end
  endtask

  task automatic test_load_align();
    logic [2:0]  lt[3]  = '{3'b001, 3'b010, 3'b011};
    logic [1:0]  al[3]  = '{2'd3, 2'd3, 2'd2};
    logic [31:0] res[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus = mk_es(1'b1, 1'b1, lt[i], al[i], 1'b1, 5'(8 + i), 32'h1000, 32'h100 + 32'(i * 4));
      exp_q.push_back(mk_ws(1'b1, 5'(8 + i), res[i], 32'h100 + 32'(i * 4)));
      @(posedge clk); #1;
      ms_if.es_to_ms_valid = 1'b0;
      checks++;
      if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_allowin !== 1'b0) begin
        errors++;
        $display("FAIL load_wait_%0d: valid=%b allowin=%b want 0/0", i,
                 ms_if.ms_to_ws_valid, ms_if.ms_allowin);
      end
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata = 32'h80FF_0000;
      @(posedge clk); #1;
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata = 32'h0;
    end
  endtask

  task automatic test_wb_stall();
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus = mk_es(1'b1, 1'b1, 3'b000, 2'd0, 1'b1, 5'd7, 32'h2000, 32'h200);
    exp_q.push_back(mk_ws(1'b1, 5'd7, 32'hCAFEBABE, 32'h200));
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.ws_allowin = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata = 32'hDEADDEAD;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ms_if.ms_allowin !== 1'b0 || ms_if.ms_to_ws_valid !== 1'b1 ||
          ms_if.ms_to_ws_bus[63:32] !== 32'hCAFEBABE) begin
        errors++;
        $display("FAIL stall_hold_%0d: allowin=%b valid=%b result=%h want 0/1/cafebabe", i,
                 ms_if.ms_allowin, ms_if.ms_to_ws_valid, ms_if.ms_to_ws_bus[63:32]);
      end
      @(posedge clk); #1;
    end
    ms_if.ws_allowin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ms_if.ms_allowin !== 1'b1 || ms_if.ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: allowin=%b valid=%b want 1/0", ms_if.ms_allowin, ms_if.ms_to_ws_valid);
    end
  endtask

  task automatic test_long_wait();
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus = mk_es(1'b1, 1'b1, 3'b100, 2'd2, 1'b1, 5'd9, 32'h3000, 32'h300);
    exp_q.push_back(mk_ws(1'b1, 5'd9, 32'h0000ABCD, 32'h300));
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_allowin !== 1'b0) begin
        errors++;
        $display("FAIL long_wait_%0d: valid=%b allowin=%b want 0/0", i,
                 ms_if.ms_to_ws_valid, ms_if.ms_allowin);
      end
`ifdef MS_FWD_DATA_EN
      checks++;
      if (ms_if.ms_fwd_blk_bus[32] !== 1'b1 || ms_if.ms_fwd_blk_bus[38:33] !== 6'b101001) begin
        errors++;
        $display("FAIL fwd_blk_%0d: fwd=%h want blk=1 wen=1 dest=9", i, ms_if.ms_fwd_blk_bus);
      end
`else
      checks++;
      if (ms_if.ms_fwd_blk_bus !== 6'b101001) begin
        errors++;
        $display("FAIL fwd_dest_%0d: fwd=%b want 101001", i, ms_if.ms_fwd_blk_bus);
      end
`endif
      @(posedge clk); #1;
    end
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata = 32'hABCD_1234;
    #1;
`ifdef MS_FWD_DATA_EN
    checks++;
    if (ms_if.ms_fwd_blk_bus[32] !== 1'b0 || ms_if.ms_fwd_blk_bus[31:0] !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL fwd_release: fwd=%h want blk=0 data=0000abcd", ms_if.ms_fwd_blk_bus);
    end
`endif
    @(posedge clk); #1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus = mk_es(1'b1, 1'b1, 3'b000, 2'd0, 1'b1, 5'd11, 32'h4000, 32'h400);
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_to_ws_bus !== 70'h0 ||
        ms_if.ms_allowin !== 1'b1 || ms_if.ms_fwd_blk_bus !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b bus=%h allowin=%b fwd=%h want 0/0/1/0",
               ms_if.ms_to_ws_valid, ms_if.ms_to_ws_bus, ms_if.ms_allowin, ms_if.ms_fwd_blk_bus);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    ms_if.data_sram_data_ok = 1'b0;
    checks++;
    if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_to_ws_bus !== 70'h0 || ms_if.ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL late_data_ok: valid=%b bus=%h allowin=%b want 0/0/1",
               ms_if.ms_to_ws_valid, ms_if.ms_to_ws_bus, ms_if.ms_allowin);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (ms_if.ms_to_ws_valid !== 1'b1 || ms_if.ms_allowin !== 1'b1) begin
          errors++;
          $display("FAIL b2b_bubble_%0d: valid=%b allowin=%b want 1/1", i,
                   ms_if.ms_to_ws_valid, ms_if.ms_allowin);
        end
      end
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus = mk_es(1'b0, 1'b0, 3'b000, 2'd0, 1'(i & 1), 5'(16 + i),
                                 32'hA000 + 32'(i), 32'h500 + 32'(i * 4));
      exp_q.push_back(mk_ws(1'(i & 1), 5'(16 + i), 32'hA000 + 32'(i), 32'h500 + 32'(i * 4)));
    end
    @(posedge clk); #1;
    ms_if.es_to_ms_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    // Scoreboard: every WB handshake pops and compares one expected payload
    fork
      forever begin
        @(negedge clk);
        if (resetn && ms_if.ms_to_ws_valid && ms_if.ws_allowin) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h with nothing expected", ms_if.ms_to_ws_bus);
          end else begin
            logic [69:0] e;
            e = exp_q.pop_front();
            if (ms_if.ms_to_ws_bus !== e) begin
              errors++;
              $display("FAIL sb_payload: got %h want %h", ms_if.ms_to_ws_bus, e);
            end
          end
        end
      end
    join_none

    test_reset();
    test_alu();
    test_load_align();
    test_wb_stall();
    test_long_wait();
    test_reset_mid_wait();
    test_back_to_back();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries never emitted, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EXE and WB. Latches the EXE payload, waits for the data-SRAM `data_ok` response of any request EXE issued, buffers that response if WB stalls, aligns and extends load data, and presents the write-back payload to WB over a valid/allowin handshake. Also reports its pending destination register to ID for forwarding and blocking.

## Interface
- `ES_TO_MS_BUS_WD`, 77, width of the payload from EXE.
- `MS_TO_WS_BUS_WD`, 70, width of the payload to WB.
- `clk`  in  1  clock; all state on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ms_allowin`  out  1  stage can accept an EXE entry this cycle.
- `es_to_ms_valid`  in  1  EXE payload valid.
- `es_to_ms_bus`  in  77  fields by bit range:
  - [76] mem_req: EXE had a load/store request accepted.
  - [75] is_load.
  - [74:72] ld_type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
  - [71:70] addr_lo.
  - [69] gr_we.
  - [68:64] dest.
  - [63:32] alu_result.
  - [31:0] pc.
- `ws_allowin`  in  1  WB can accept.
- `ms_to_ws_valid`  out  1  payload to WB valid.
- `ms_to_ws_bus`  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- `data_sram_data_ok`  in  1  one-cycle response pulse for the single outstanding request.
- `data_sram_rdata`  in  32  response data, valid with `data_ok`.
- `ms_fwd_blk_bus`  out  6 or 39  see Configuration.

## Operation
- Registers:
  - `ms_valid`
  - payload register `es_to_ms_bus_r`
  - `rdata_ok_r`
  - `rdata_r[31:0]`
- `ms_ready_go = !mem_req || data_sram_data_ok || rdata_ok_r`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- `ms_valid` update:
  - When `ms_allowin`: `ms_valid <= es_to_ms_valid`.
  - When `es_to_ms_valid && ms_allowin`: the payload register loads.
- Response buffer:
  - `data_ok` while `ms_valid && mem_req && !rdata_ok_r` and the entry is not leaving this cycle: set `rdata_ok_r`, capture `rdata_r`.
  - `rdata_ok_r` clears whenever the entry leaves (`ms_to_ws_valid && ws_allowin`).
  - Response mux: `mem_rdata = rdata_ok_r ? rdata_r : data_sram_rdata`.
- Load alignment:
  - LW: full word.
  - LB/LBU: byte `addr_lo*8 +: 8`, sign- or zero-extended.
  - LH/LHU: halfword at `addr_lo[1]*16 +: 16`, sign- or zero-extended.
  - Reserved ld_type codes behave as LW.
- `final_result = is_load ? aligned_data : alu_result`. Stores pass `alu_result` and `gr_we` unchanged; `gr_we` is 0 from EXE.
- A `data_ok` arriving while `!ms_valid` or `!mem_req` is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert by system): `ms_valid=0`, `rdata_ok_r=0`, `rdata_r=0`, payload register = 0.
  - Hence `ms_to_ws_valid=0`, `ms_to_ws_bus=0`, `ms_allowin=1`, `ms_fwd_blk_bus=0`.
- Latency:
  - Non-memory entry: 1 cycle in stage when WB allows.
  - Memory entry: leaves in the cycle `data_ok` arrives (combinational path `rdata` -> `ms_to_ws_bus`), or later from the buffer.
- WB stall while response present: the buffer holds; the bus is stable until `ws_allowin`.
- Simultaneous leave and enter: the new entry loads the same edge; `rdata_ok_r` clears.
- Reset mid-wait discards the entry; a late `data_ok` after reset is ignored (`ms_valid=0`).

## Configuration
- `MS_FWD_DATA_EN` defined: `ms_fwd_blk_bus` is 39 bits: {`ms_rf_wen`[38], `ms_rf_dest`[37:33], `ms_fwd_blk`[32], `ms_fwd_data`[31:0]}.
  - `ms_rf_wen = ms_valid && gr_we`.
  - `ms_fwd_blk = ms_valid && is_load && !ms_ready_go`.
  - `ms_fwd_data = final_result`.
- Undefined: the bus is 6 bits, {`ms_rf_wen`, `ms_rf_dest`}. ID blocks on any dest match.

## Test plan
- ALU entry `pc=0xBFC00000`, `dest=5`, `alu_result=0x1234`, `gr_we=1`, `ws_allowin=1` -> `ms_to_ws_valid` high next cycle, bus = {1, 5, 0x1234, 0xBFC00000}, one cycle only.
- LB with `addr_lo=3`, `data_ok` one cycle after entry with `rdata=0x80FF_0000` -> `final_result=0xFFFFFF80`. LBU same -> `0x00000080`. LH with `addr_lo=2` -> `0xFFFF80FF`.
- Load, `data_ok` arrives while `ws_allowin=0` for 3 cycles, `rdata` then changes to junk -> buffered value delivered when `ws_allowin` rises; `ms_allowin` low throughout.
- Load waiting 4 cycles for `data_ok` -> `ms_to_ws_valid=0`, `ms_allowin=0`. With `MS_FWD_DATA_EN`, `ms_fwd_blk=1` until `data_ok`.
- `resetn` pulsed low while a load waits, then `data_ok` arrives -> all outputs 0, `ms_allowin=1`, no entry emitted.
- Back-to-back ALU entries with `ws_allowin=1` -> one entry per cycle, no bubbles.
